// File: rtl/hp_bar_anim.sv
// Animated HP bar: drains the displayed HP toward each accepted damage result on
// frame ticks, holds, then pulses done. Optional skip input under HP_BAR_SKIP_EN.
module hp_bar_anim #(
    parameter int HP_W        = 6,
    parameter int MAX_HP      = 63,
    parameter int STEP_FRAMES = 2,
    parameter int HOLD_FRAMES = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            frame_tick,
    input  logic            dmg_valid,
    output logic            dmg_ready,
    input  logic [HP_W-1:0] hp_target,
    input  logic            faint_in,
    input  logic            new_battle,
`ifdef HP_BAR_SKIP_EN
    input  logic            skip,
`endif
    output logic [HP_W-1:0] hp_disp,
    output logic [1:0]      hp_color,
    output logic            busy,
    output logic            done,
    output logic            faint_out
);

    localparam int CNT_MAX = (STEP_FRAMES > HOLD_FRAMES) ? STEP_FRAMES : HOLD_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, HOLD, FAINTED} state_t;

    state_t            state_q, state_d;
    logic [HP_W-1:0]   hp_q, hp_d;
    logic [HP_W-1:0]   tgt_q, tgt_d;
    logic              faint_lat_q, faint_lat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              skip_req;
    logic [HP_W-1:0]   hp_dec;
    logic [HP_W-1:0]   acc_tgt;

`ifdef HP_BAR_SKIP_EN
    assign skip_req = skip;
`else
    assign skip_req = 1'b0;
`endif

    assign hp_dec  = hp_q - HP_W'(1);
    assign acc_tgt = faint_in ? '0 : hp_target;

    always_comb begin
        state_d     = state_q;
        hp_d        = hp_q;
        tgt_d       = tgt_q;
        faint_lat_d = faint_lat_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        if (new_battle) begin
            state_d     = IDLE;
            hp_d        = HP_W'(MAX_HP);
            tgt_d       = '0;
            faint_lat_d = 1'b0;
            cnt_d       = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dmg_valid) begin
                        tgt_d       = acc_tgt;
                        faint_lat_d = faint_in;
                        cnt_d       = '0;
                        state_d     = (acc_tgt < hp_q) ? DRAIN : HOLD;
                    end
                end
                DRAIN: begin
                    // skip beats a coincident frame tick; the tick is simply not counted
                    if (skip_req) begin
                        hp_d    = tgt_q;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else if (frame_tick) begin
                        if (cnt_q == CNT_W'(STEP_FRAMES - 1)) begin
                            cnt_d = '0;
                            if (hp_q != '0) hp_d = hp_dec;
                            if (hp_dec == tgt_q || hp_q == '0) state_d = HOLD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (frame_tick) begin
                        if (cnt_q == CNT_W'(HOLD_FRAMES - 1)) begin
                            cnt_d   = '0;
                            done_d  = 1'b1;
                            state_d = (hp_q == '0 || faint_lat_q) ? FAINTED : IDLE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            hp_q        <= HP_W'(MAX_HP);
            tgt_q       <= '0;
            faint_lat_q <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hp_q        <= hp_d;
            tgt_q       <= tgt_d;
            faint_lat_q <= faint_lat_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
        end
    end

    // Thresholds compared with two spare bits so 4*hp cannot overflow
    logic [HP_W+1:0] hp_x2, hp_x4, max_ext;
    assign hp_x2   = {1'b0, hp_q, 1'b0};
    assign hp_x4   = {hp_q, 2'b00};
    assign max_ext = (HP_W+2)'(MAX_HP);

    always_comb begin
        hp_color = 2'b10;
        if (hp_x2 > max_ext)      hp_color = 2'b00;
        else if (hp_x4 > max_ext) hp_color = 2'b01;
    end

    assign hp_disp   = hp_q;
    assign dmg_ready = (state_q == IDLE);
    assign busy      = (state_q == DRAIN) || (state_q == HOLD);
    assign done      = done_q;
    assign faint_out = (state_q == FAINTED);

endmodule

// File: tb/tb_hp_bar_anim.sv
// Bench for hp_bar_anim: tick-count reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_hp_bar_anim;
    localparam int HP_W = 6, MAXHP = 63, STEP = 2, HOLDF = 4;

    logic clk = 0, reset_n = 1, frame_tick = 0, dmg_valid = 0, faint_in = 0, new_battle = 0, skip = 0;
    logic [HP_W-1:0] hp_target = 0;
    logic dmg_ready, busy, done, faint_out;
    logic [HP_W-1:0] hp_disp;
    logic [1:0] hp_color;

    hp_bar_anim #(.HP_W(HP_W), .MAX_HP(MAXHP), .STEP_FRAMES(STEP), .HOLD_FRAMES(HOLDF)) dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .dmg_valid(dmg_valid),
        .dmg_ready(dmg_ready), .hp_target(hp_target), .faint_in(faint_in), .new_battle(new_battle),
`ifdef HP_BAR_SKIP_EN
        .skip(skip),
`endif
        .hp_disp(hp_disp), .hp_color(hp_color), .busy(busy), .done(done), .faint_out(faint_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0, done_cnt = 0;
    bit cmp_en = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a transaction is described by start HP, target and frame ticks since accept
    localparam int M_IDLE = 0, M_BUSY = 1, M_FAINT = 2;
    int m_mode = M_IDLE, m_hp = MAXHP, m_start = 0, m_tgt = 0, m_ticks = 0;
    bit m_faint = 0, m_done = 0;

    function automatic int m_steps();
        return (m_start > m_tgt) ? m_start - m_tgt : 0;
    endfunction

    function automatic int m_hp_now();
        int d;
        if (m_mode != M_BUSY) return m_hp;
        d = m_ticks / STEP;
        if (d > m_steps()) d = m_steps();
        return m_start - d;
    endfunction

    function automatic int color_of(input int h);
        if (2 * h > MAXHP) return 0;
        if (4 * h > MAXHP) return 1;
        return 2;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode <= M_IDLE; m_hp <= MAXHP; m_faint <= 0; m_done <= 0; m_ticks <= 0;
        end else begin : upd
            int t, fin;
            m_done <= 0;
            if (new_battle) begin
                m_mode <= M_IDLE; m_hp <= MAXHP; m_faint <= 0; m_ticks <= 0;
            end else if (m_mode == M_IDLE && dmg_valid) begin
                m_tgt   <= faint_in ? 0 : int'(hp_target);
                m_start <= m_hp;
                m_faint <= faint_in;
                m_ticks <= 0;
                m_mode  <= M_BUSY;
            end else if (m_mode == M_BUSY) begin
                t = m_ticks;
                if (skip && t < m_steps() * STEP) t = m_steps() * STEP;
                else if (frame_tick) t = t + 1;
                m_ticks <= t;
                if (t == m_steps() * STEP + HOLDF) begin
                    fin = m_start - m_steps();
                    m_done <= 1;
                    m_hp   <= fin;
                    m_mode <= (fin == 0 || m_faint) ? M_FAINT : M_IDLE;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (cmp_en) begin
            chk("hp_disp", int'(hp_disp), m_hp_now());
            chk("hp_color", int'(hp_color), color_of(m_hp_now()));
            chk("dmg_ready", int'(dmg_ready), int'(m_mode == M_IDLE));
            chk("busy", int'(busy), int'(m_mode == M_BUSY));
            chk("done", int'(done), int'(m_done));
            chk("faint_out", int'(faint_out), int'(m_mode == M_FAINT));
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1; step(); frame_tick = 0; step();
        end
    endtask

    task automatic accept(input int tgt, input bit f);
        dmg_valid = 1; hp_target = HP_W'(tgt); faint_in = f; step();
        dmg_valid = 0; faint_in = 0;
    endtask

    task automatic nb();
        new_battle = 1; step(); new_battle = 0; step();
    endtask

    int d0;
    initial begin
        #1 reset_n = 0;
        cmp_en = 1;
        step(); step();
        reset_n = 1; step();
        chk("rst_hp", int'(hp_disp), 63);
        chk("rst_ready", int'(dmg_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_color", int'(hp_color), 0);
        chk("rst_faint", int'(faint_out), 0);

        // 63 -> 42
        d0 = done_cnt;
        accept(42, 0);
        ticks(42);
        chk("drain_hp", int'(hp_disp), 42);
        chk("drain_busy", int'(busy), 1);
        ticks(3);
        chk("hold_nodone", done_cnt - d0, 0);
        ticks(1); step();
        chk("drain_done", done_cnt - d0, 1);
        chk("drain_idle", int'(dmg_ready), 1);
        chk("drain_color", int'(hp_color), 0);

        // 42 -> 0 with faint
        d0 = done_cnt;
        accept(0, 1);
        ticks(22);
        chk("hp31", int'(hp_disp), 31);
        chk("col_yellow", int'(hp_color), 1);
        ticks(32);
        chk("hp15", int'(hp_disp), 15);
        chk("col_red", int'(hp_color), 2);
        ticks(30 + HOLDF); step();
        chk("faint_done", done_cnt - d0, 1);
        chk("faint_out", int'(faint_out), 1);
        chk("faint_ready", int'(dmg_ready), 0);
        accept(5, 0);
        ticks(3);
        chk("faint_ignore", int'(hp_disp), 0);

        // heal is not animated
        nb();
        accept(42, 0); ticks(42 + HOLDF);
        d0 = done_cnt;
        accept(50, 0);
        ticks(2);
        chk("heal_hp", int'(hp_disp), 42);
        ticks(2); step();
        chk("heal_done", done_cnt - d0, 1);
        chk("heal_idle", int'(dmg_ready), 1);

        // new_battle with a coincident tick mid-drain
        accept(30, 0); ticks(5);
        d0 = done_cnt;
        new_battle = 1; frame_tick = 1; step();
        new_battle = 0; frame_tick = 0;
        chk("nb_hp", int'(hp_disp), 63);
        chk("nb_ready", int'(dmg_ready), 1);
        ticks(6);
        chk("nb_nodone", done_cnt - d0, 0);

        // async reset mid-HOLD
        accept(60, 0); ticks(3 * STEP + 2);
        chk("pre_rst_busy", int'(busy), 1);
        reset_n = 0; #1;
        chk("arst_hp", int'(hp_disp), 63);
        chk("arst_busy", int'(busy), 0);
        chk("arst_ready", int'(dmg_ready), 1);
        chk("arst_done", int'(done), 0);
        #3 reset_n = 1; step();

`ifdef HP_BAR_SKIP_EN
        d0 = done_cnt;
        accept(10, 0); ticks(3);
        skip = 1; step(); skip = 0;
        chk("skip_hp", int'(hp_disp), 10);
        chk("skip_busy", int'(busy), 1);
        ticks(HOLDF); step();
        chk("skip_done", done_cnt - d0, 1);
`endif

        // random traffic
        for (int i = 0; i < 6000; i++) begin
            dmg_valid  = ($urandom_range(3) == 0);
            hp_target  = HP_W'($urandom_range(63));
            faint_in   = ($urandom_range(7) == 0);
            frame_tick = ($urandom_range(1) == 0);
            new_battle = ($urandom_range(150) == 0);
`ifdef HP_BAR_SKIP_EN
            skip       = ($urandom_range(40) == 0);
`endif
            step();
        end
        dmg_valid = 0; frame_tick = 0; new_battle = 0; skip = 0;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/hp_bar_anim.md
# hp_bar_anim

Display-side consumer of the battle damage calculator. It accepts each new HP value produced by the damage stage and animates the on-screen HP bar, lowering the displayed HP one point at a time on video-frame ticks. After draining it holds briefly, then reports completion to the battle controller and latches the faint condition. It sits between the damage calculator (upstream) and the sprite/HP-bar renderer (downstream).

## Interface
- HP_W, 6, width of all HP values
- MAX_HP, 63, HP loaded at reset and at new_battle
- STEP_FRAMES, 2, frame ticks per 1-point HP decrement (≥1)
- HOLD_FRAMES, 4, frame ticks of pause after drain before done (≥1)

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per video frame
- dmg_valid  in  1  new HP result offered by the damage stage
- dmg_ready  out  1  block accepts a result; high only in IDLE
- hp_target  in  HP_W  new HP from the damage stage
- faint_in  in  1  faint flag from the damage stage
- new_battle  in  1  synchronous reload to MAX_HP
- hp_disp  out  HP_W  currently displayed HP
- hp_color  out  2  00 green, 01 yellow, 10 red
- busy  out  1  high in DRAIN or HOLD
- done  out  1  one-cycle pulse at end of HOLD
- faint_out  out  1  sticky; high in FAINTED

## Operation
- States: IDLE, DRAIN, HOLD, FAINTED.
- Reset (async) and new_battle (sync) produce the same result: hp_disp=MAX_HP, state IDLE, counters=0, done=0, faint_out=0. Outputs after reset: dmg_ready=1, busy=0, hp_color=00.
- new_battle has priority over all other inputs in every state. It suppresses any done pulse.
- Accept occurs when dmg_valid && dmg_ready:
  - Latch tgt = faint_in ? 0 : hp_target.
  - Latch faint_lat = faint_in.
  - If tgt < hp_disp, go to DRAIN. Otherwise go to HOLD, and hp_disp is unchanged (healing is not animated).
- DRAIN:
  - The frame counter counts frame_tick pulses. On the STEP_FRAMES-th tick, decrement hp_disp by 1 and clear the counter.
  - When the decrement makes hp_disp == tgt, go to HOLD with the counter cleared.
- HOLD:
  - On the HOLD_FRAMES-th frame_tick, pulse done.
  - Then go to FAINTED if (hp_disp == 0 || faint_lat). Otherwise go to IDLE.
- FAINTED:
  - dmg_ready=0, faint_out=1.
  - dmg_valid is ignored. Only new_battle or reset exits this state.
- hp_color is computed from registered hp_disp in HP_W+2-bit arithmetic:
  - green if 2·hp_disp > MAX_HP
  - else yellow if 4·hp_disp > MAX_HP
  - else red
- hp_disp never wraps below 0 and never exceeds MAX_HP.

## Timing
- dmg_ready is decoded from the state register. The accept cycle is the cycle where it and dmg_valid are both high.
- The first DRAIN/HOLD cycle follows the accept edge. A frame_tick during the accept cycle is not counted.
- Drain latency: hp_disp reaches tgt on the edge of the ((hp_disp_start − tgt)·STEP_FRAMES)-th frame_tick after accept.
- done:
  - It is registered and high for exactly one cycle, coinciding with the first cycle in IDLE/FAINTED.
  - In that cycle faint_out is already valid, and in IDLE dmg_ready is already 1.
- busy equals (state==DRAIN || state==HOLD) and is decoded from the state register.
- frame_tick and new_battle in the same cycle: new_battle wins and the tick is dropped.
- Reset asserted mid-DRAIN: all outputs take their reset values immediately, asynchronously.

## Configuration
- HP_BAR_SKIP_EN defined:
  - Adds input skip (1 bit).
  - skip=1 in DRAIN sets hp_disp=tgt on the next edge and enters HOLD with the counter cleared.
  - skip is ignored in all other states.
- HP_BAR_SKIP_EN undefined: the port is absent and draining always runs to completion.

## Test plan
- Reset: hold reset_n=0, then release → hp_disp=63, dmg_ready=1, busy=0, done=0, faint_out=0, hp_color=00.
- Drain: hp_disp=63, accept hp_target=42, faint_in=0 → hp_disp=42 after 42 frame ticks with busy=1. done pulses after 4 more ticks. State returns to IDLE and hp_color stays 00.
- Colors and faint: from 42, accept hp_target=0, faint_in=1:
  - hp_color → 01 when hp_disp=31.
  - hp_color → 10 when hp_disp=15.
  - At 0 plus 4 ticks: done pulse, faint_out=1, dmg_ready=0.
  - A subsequent dmg_valid is ignored.
- No drain: hp_disp=42, accept hp_target=50 → hp_disp stays 42. done pulses on the 4th tick and the block returns to IDLE.
- Interrupts:
  - new_battle mid-DRAIN, at the same cycle as a frame_tick → next cycle hp_disp=63, IDLE, no done pulse.
  - reset_n low mid-HOLD → immediate reset values.
- HP_BAR_SKIP_EN build: accept 10 from 63, pulse skip after 3 ticks → next cycle hp_disp=10 and state HOLD. done pulses after 4 ticks.
